// File: rtl/lsu_busseq.sv
// Sequences an up-to-8-byte load/store onto a one-byte bus, one byte per address cycle; BUSSEQ_ALIGN_CHECK_EN adds a misalignment error.
// Latency: store N bytes -> response after N+1 cycles; load -> 1+N*(1+READ_LAT) cycles; misaligned with check -> 1 cycle.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module lsu_busseq #(
   parameter int READ_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]  state;
   logic        we_q;
   logic [1:0]  size_q;
   logic [63:0] base_q;
   logic [63:0] wdata_q;
   logic [63:0] rdata_q;
   logic [2:0]  idx_q;
   logic [2:0]  last_idx;
   logic [2:0]  nidx;
   logic [3:0]  wcnt_q;

   always_comb begin
      case (size_q)
         2'd0:    last_idx = 3'd0;
         2'd1:    last_idx = 3'd1;
         2'd2:    last_idx = 3'd3;
         default: last_idx = 3'd7;
      endcase
   end

   assign nidx      = idx_q + 3'd1;
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_rdata = rsp_valid ? rdata_q : 64'd0;

`ifdef BUSSEQ_ALIGN_CHECK_EN
   logic err_q;
   logic misalign;

   always_comb begin
      case (req_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = req_addr[0];
         2'd2:    misalign = |req_addr[1:0];
         default: misalign = |req_addr[2:0];
      endcase
   end

   assign rsp_err = rsp_valid & err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Bus outputs are registered from the next-state decision so they are valid for the whole XFER cycle
   // and simply hold their value in every other state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         we_q      <= 1'b0;
         size_q    <= 2'd0;
         base_q    <= 64'd0;
         wdata_q   <= 64'd0;
         rdata_q   <= 64'd0;
         idx_q     <= 3'd0;
         wcnt_q    <= 4'd0;
         bus_we    <= 1'b0;
         bus_addr  <= 64'd0;
         bus_wdata <= 8'd0;
`ifdef BUSSEQ_ALIGN_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         bus_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  base_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rdata_q <= 64'd0;
                  idx_q   <= 3'd0;
`ifdef BUSSEQ_ALIGN_CHECK_EN
                  err_q   <= misalign;
                  if (misalign) begin
                     state <= ST_RESP;
                  end else
`endif
                  begin
                     state     <= ST_XFER;
                     bus_we    <= req_we;
                     bus_addr  <= req_addr;
                     bus_wdata <= req_we ? req_wdata[7:0] : 8'd0;
                  end
               end
            end
            ST_XFER: begin
               if (we_q) begin
                  if (idx_q == last_idx) begin
                     state <= ST_RESP;
                  end else begin
                     idx_q     <= nidx;
                     bus_we    <= 1'b1;
                     bus_addr  <= base_q + 64'(nidx);
                     bus_wdata <= wdata_q[{nidx, 3'b000} +: 8];
                  end
               end else begin
                  state  <= ST_WAIT;
                  wcnt_q <= 4'(READ_LAT - 1);
               end
            end
            ST_WAIT: begin
               if (wcnt_q == 4'd0) begin
                  rdata_q[{idx_q, 3'b000} +: 8] <= bus_rdata;
                  if (idx_q == last_idx) begin
                     state <= ST_RESP;
                  end else begin
                     state     <= ST_XFER;
                     idx_q     <= nidx;
                     bus_addr  <= base_q + 64'(nidx);
                     bus_wdata <= 8'd0;
                  end
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            default: begin
               if (rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_busseq.sv
// Randomized and directed checks of lsu_busseq against a byte-level reference model of each access.
module tb_lsu_busseq;

   localparam int READ_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;

   int n_chk = 0;
   int n_err = 0;

   logic [63:0] wa_q[$];
   logic [7:0]  wd_q[$];
   logic [63:0] exp_wa[$];
   logic [7:0]  exp_wd[$];

   lsu_busseq #(.READ_LAT(READ_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: each byte reads as a fixed function of its address.
   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   assign bus_rdata = mem_byte(bus_addr);

   always @(negedge clk) begin
      if (bus_we) begin
         wa_q.push_back(bus_addr);
         wd_q.push_back(bus_wdata);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
      check({tag, "_rsp_rdata"}, rsp_rdata,      64'd0);
      check({tag, "_bus_we"},    64'(bus_we),    64'd0);
      check({tag, "_bus_addr"},  bus_addr,       64'd0);
      check({tag, "_bus_wdata"}, 64'(bus_wdata), 64'd0);
   endtask

   task automatic run_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                          input logic [63:0] wdata, input int hold);
      int          n;
      int          lat;
      int          k;
      logic [63:0] exp_rd;
      logic        exp_err;
      logic [63:0] a;
      n       = 1 << size;
      exp_err = 1'b0;
`ifdef BUSSEQ_ALIGN_CHECK_EN
      exp_err = (addr % 64'(n)) != 64'd0;
`endif
      exp_wa.delete();
      exp_wd.delete();
      exp_rd = 64'd0;
      if (exp_err) begin
         lat = 1;
      end else begin
         lat = we ? n + 1 : 1 + n * (1 + READ_LAT);
         for (int i = 0; i < n; i++) begin
            a = addr + 64'(i);
            if (we) begin
               exp_wa.push_back(a);
               exp_wd.push_back(wdata[8*i +: 8]);
            end else begin
               exp_rd[8*i +: 8] = mem_byte(a);
            end
         end
      end

      @(negedge clk);
      wa_q.delete();
      wd_q.delete();
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      // Junk on the request fields while busy must not disturb the transfer.
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_size  = 2'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};

      k = 1;
      @(negedge clk);
      while (!rsp_valid && k < 400) begin
         check("busy_req_ready", 64'(req_ready), 64'd0);
         @(negedge clk);
         k++;
      end
      check("rsp_latency", 64'(k), 64'(lat));
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", 64'(rsp_err), 64'(exp_err));

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
         check("hold_rsp_rdata", rsp_rdata, exp_rd);
         check("hold_req_ready", 64'(req_ready), 64'd0);
      end

      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("after_rsp_req_ready", 64'(req_ready), 64'd1);
      check("after_rsp_valid", 64'(rsp_valid), 64'd0);

      check("bus_write_count", 64'(wa_q.size()), 64'(exp_wa.size()));
      for (int i = 0; i < exp_wa.size() && i < wa_q.size(); i++) begin
         check("bus_write_addr", wa_q[i], exp_wa[i]);
         check("bus_write_data", 64'(wd_q[i]), 64'(exp_wd[i]));
      end
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'd0;
      req_addr  = 64'd0;
      req_wdata = 64'd0;
      rsp_ready = 1'b0;
      #2;
      check_reset_outputs("por");
      repeat (3) @(negedge clk);
      reset = 1'b1;

      run_req(1'b1, 2'd3, 64'h1000, 64'h8877665544332211, 0);
      run_req(1'b0, 2'd2, 64'h20, 64'd0, 0);
      run_req(1'b0, 2'd1, 64'h3, 64'd0, 0);
      run_req(1'b0, 2'd3, 64'h4000, 64'd0, 5);
      run_req(1'b1, 2'd1, 64'hFFFFFFFFFFFFFFFF, 64'h0000_0000_0000_BEEF, 2);
      run_req(1'b1, 2'd0, 64'h7, 64'h55, 1);

      // Asynchronous reset in the middle of an 8-byte load, after three bytes were sampled.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'd3;
      req_addr  = 64'h0000_0000_0000_0500;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3 * (1 + READ_LAT) + 1) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      end
      run_req(1'b0, 2'd3, 64'h0000_0000_0000_0500, 64'd0, 0);

      for (int t = 0; t < 40; t++) begin
         logic [63:0] addr;
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) addr = 64'hFFFFFFFFFFFFFFF8 | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) addr = addr & ~64'h7;
         run_req(1'($urandom), 2'($urandom), addr, {$urandom, $urandom}, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_busseq.md
LSU_BUSSEQ -- requirements
Module: lsu_busseq

Interface
REQ-001 Parameter READ_LAT, default 2: cycles from a read byte's address cycle to the bus_rdata sample; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 req_valid  input  1  upstream request valid.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  access size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-008 req_addr  input  64  byte address of the access.
REQ-009 req_wdata  input  64  store data; byte i is bits [8i+7:8i].
REQ-010 rsp_valid  output  1  response valid; held until taken.
REQ-011 rsp_ready  input  1  upstream takes the response.
REQ-012 rsp_rdata  output  64  load data, zero-extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned-access error flag, qualified by rsp_valid.
REQ-014 bus_we  output  1  byte-bus write enable; drives the bus controller's bus_we.
REQ-015 bus_addr  output  64  byte-bus address; drives the bus controller's bus_addr.
REQ-016 bus_wdata  output  8  byte-bus write data; drives the bus controller's bus_data_in.
REQ-017 bus_rdata  input  8  byte-bus read data, from the bus controller's bus_data_out.

Function
REQ-018 FSM states SHALL be IDLE, XFER, WAIT and RESP; req_ready=1 only in IDLE.
REQ-019 Acceptance: IDLE with req_valid=1 latches we/size/addr/wdata, clears byte index i, sets N=1<<req_size, and goes to XFER.
REQ-020 XFER drives bus_addr=base+i (modulo 2^64), bus_we=latched we, and bus_wdata=byte i of wdata (0 for loads).
REQ-021 Store: each XFER cycle writes one byte; after byte N-1 the FSM goes to RESP, otherwise i increments and XFER repeats.
REQ-022 Load: after XFER the FSM enters WAIT for READ_LAT cycles, holding bus_addr with bus_we=0.
REQ-023 Load sampling: on the last WAIT cycle bus_rdata is stored into rdata byte i; the FSM then goes to RESP if i=N-1, else increments i and returns to XFER.
REQ-024 Latency: a store of N bytes accepted in cycle T drives bytes in T+1..T+N, with rsp_valid first high in T+N+1.
REQ-025 Latency: a load shows rsp_valid first high in T+1+N*(1+READ_LAT).
REQ-026 Outside XFER, bus_we=0 and bus_addr/bus_wdata hold their last driven values.
REQ-027 RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then goes to IDLE; no new request is accepted in the same cycle.
REQ-028 Unloaded rdata bytes above N SHALL read 0.
REQ-029 req_* inputs are ignored outside IDLE; back-to-back requests complete in order, one outstanding at a time.

Reset
REQ-030 On reset=0 the block immediately, regardless of clk, enters IDLE, drives req_ready=1, and forces rsp_valid, rsp_err, bus_we and rsp_rdata to 0.
REQ-031 Reset also forces bus_addr=0, bus_wdata=0, clears i and the latched request, and discards any in-flight transfer with no response emitted.
REQ-032 Deassertion is sampled synchronously to clk; the first request can be accepted on the first rising edge with reset=1.

Configuration
REQ-033 With BUSSEQ_ALIGN_CHECK_EN defined, a request whose req_addr is not a multiple of N goes from IDLE directly to RESP with rsp_err=1 and rsp_rdata=0, issuing no bus cycles.
REQ-034 Without BUSSEQ_ALIGN_CHECK_EN, misaligned requests proceed bytewise per REQ-020..023 (addresses wrap modulo 2^64), and rsp_err is constantly 0.

Verification
REQ-035 Store 8B, addr 0x1000, wdata 0x8877665544332211 -> bus_we=1 at 0x1000..0x1007 with bytes 0x11..0x88 on consecutive cycles; rsp_valid at T+9, rsp_err=0.
REQ-036 Load 4B, addr 0x20, READ_LAT=2, bus_rdata model returning addr[7:0] -> rsp_rdata=0x0000000023222120 at T+13.
REQ-037 Response with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; IDLE entered the cycle after rsp_ready=1.
REQ-038 With BUSSEQ_ALIGN_CHECK_EN, load 2B at addr 0x3 -> no bus_we or bus_addr activity, rsp_err=1, rsp_rdata=0 at T+1.
REQ-039 Without BUSSEQ_ALIGN_CHECK_EN, store 2B at 0xFFFFFFFFFFFFFFFF -> bytes written at 0xFFFFFFFFFFFFFFFF then 0x0, rsp_err=0.
REQ-040 reset driven 0 mid-way through an 8B load (after byte 3) -> all outputs take reset values without a clk edge, no rsp_valid, and the next request completes correctly.
